// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port RAM with 1-cycle read latency.
// Grants are combinational; burst locks are bounded by MAX_BURST while the other side waits.
module mem_port_arbiter #(
  parameter int AW        = 14,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            r0_req,
  input  logic            r0_lock,
  input  logic            r0_we,
  input  logic [AW-1:0]   r0_addr,
  input  logic [DW-1:0]   r0_wdata,
  input  logic [DW/8-1:0] r0_be,
  output logic            r0_gnt,
  output logic            r0_rvalid,
  output logic [DW-1:0]   r0_rdata,
  input  logic            r1_req,
  input  logic            r1_lock,
  input  logic            r1_we,
  input  logic [AW-1:0]   r1_addr,
  input  logic [DW-1:0]   r1_wdata,
  input  logic [DW/8-1:0] r1_be,
  output logic            r1_gnt,
  output logic            r1_rvalid,
  output logic [DW-1:0]   r1_rdata,
  output logic            ram_cs,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  output logic [DW/8-1:0] ram_be,
  input  logic [DW-1:0]   ram_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          pend0_q, pend1_q;
  logic [DW-1:0] hold0_q, hold1_q;

  logic g0, g1, arb, preempt;

  always_comb begin
    g0      = 1'b0;
    g1      = 1'b0;
    arb     = 1'b0;
    preempt = 1'b0;
    state_d = IDLE;
    last_d  = last_q;
    cnt_d   = 8'd0;

    // An owner that stops requesting hands the cycle to plain arbitration.
    case (state_q)
      OWN0: begin
        if (cnt_q == 8'(MAX_BURST) && r1_req) begin
          g1      = 1'b1;
          preempt = 1'b1;
        end else if (r0_req) begin
          g0 = 1'b1;
        end else begin
          arb = 1'b1;
        end
      end
      OWN1: begin
        if (cnt_q == 8'(MAX_BURST) && r0_req) begin
          g0      = 1'b1;
          preempt = 1'b1;
        end else if (r1_req) begin
          g1 = 1'b1;
        end else begin
          arb = 1'b1;
        end
      end
      default: arb = 1'b1;
    endcase

    if (arb) begin
      if (r0_req && r1_req) begin
        g0 = last_q;
        g1 = ~last_q;
      end else begin
        g0 = r0_req;
        g1 = r1_req;
      end
    end

    if (g0) begin
      last_d  = 1'b0;
      state_d = r0_lock ? OWN0 : IDLE;
      if (r0_lock && r1_req && !preempt)
        cnt_d = (state_q == OWN0) ? cnt_q + 8'd1 : 8'd1;
    end else if (g1) begin
      last_d  = 1'b1;
      state_d = r1_lock ? OWN1 : IDLE;
      if (r1_lock && r0_req && !preempt)
        cnt_d = (state_q == OWN1) ? cnt_q + 8'd1 : 8'd1;
    end
  end

  assign r0_gnt = g0 & ~reset;
  assign r1_gnt = g1 & ~reset;

  assign ram_cs    = r0_gnt | r1_gnt;
  assign ram_we    = (r0_gnt & r0_we) | (r1_gnt & r1_we);
  assign ram_addr  = r1_gnt ? r1_addr  : r0_addr;
  assign ram_wdata = r1_gnt ? r1_wdata : r0_wdata;
  assign ram_be    = ram_we ? (r1_gnt ? r1_be : r0_be) : '1;

  // Pending reads are masked while reset is high so nothing leaks out of a reset cycle.
  assign r0_rvalid = pend0_q & ~reset;
  assign r1_rvalid = pend1_q & ~reset;
  assign r0_rdata  = r0_rvalid ? ram_rdata : hold0_q;
  assign r1_rdata  = r1_rvalid ? ram_rdata : hold1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      pend0_q <= g0 & ~r0_we;
      pend1_q <= g1 & ~r1_we;
      if (pend0_q) hold0_q <= ram_rdata;
      if (pend1_q) hold1_q <= ram_rdata;
    end
  end

endmodule
